// File: rtl/uart_pkg.sv
// Shared UART definitions: data/address widths, default CPU register map,
// status bit positions and the receive-buffer FSM state type.
package uart_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned NUM_SLOTS  = 4;
    localparam int unsigned SLOT_IDX_W = 2;
    localparam int unsigned CNT_W      = 3;

    // Default CPU register map: TX slots low, RX slots and RX status above them
    localparam logic [ADDR_W-1:0] TX_BASE_ADDR = 4'd0;
    localparam logic [ADDR_W-1:0] TX_LAST_ADDR = 4'd3;
    localparam logic [ADDR_W-1:0] RX_BASE_ADDR = 4'd10;
    localparam logic [ADDR_W-1:0] RX_STAT_ADDR = 4'd14;

    localparam int unsigned FULL_BIT = 0;
    localparam int unsigned OVR_BIT  = 1;
    localparam int unsigned CNT_BIT  = 2;

    typedef enum logic {
        ST_FILLING = 1'b0,
        ST_FULL    = 1'b1
    } rx_state_e;

    // Status byte layout: bit 2 is the MSB of the stored-byte count
    function automatic logic [DATA_W-1:0] rx_status(
        input logic [CNT_W-1:0] cnt,
        input logic             ovr,
        input logic             is_full
    );
        logic [DATA_W-1:0] s;
        s           = '0;
        s[FULL_BIT] = is_full;
        s[OVR_BIT]  = ovr;
        s[CNT_BIT]  = cnt[CNT_W-1];
        return s;
    endfunction

endpackage

// File: rtl/rx_buffer.sv
// Four-byte UART receive frame buffer with CPU read port. A status read
// reports full/overrun and, when the frame is full, releases it for refill.
module rx_buffer
    import uart_pkg::*;
#(
    parameter logic [3:0] BASE_ADDR = RX_BASE_ADDR,
    parameter logic [3:0] STAT_ADDR = RX_STAT_ADDR
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       rd,
    input  logic [3:0] address,
    output logic [7:0] r_data,
    output logic       full,
    output logic       overrun,
    output logic [2:0] count
);

    localparam int unsigned OFF_W = ADDR_W + 1;

    rx_state_e               state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    full_q, full_d;
    logic                    overrun_q, overrun_d;
    logic [DATA_W-1:0]       r_data_q, r_data_d;
    logic [DATA_W-1:0]       slot_q [NUM_SLOTS];
    logic                    slot_we;
    logic [SLOT_IDX_W-1:0]   slot_widx;
    logic                    armed_q;

    logic                    rx_ev;
    logic                    rd_ev;
    logic                    slot_hit;
    logic                    stat_hit;
    logic [OFF_W-1:0]        slot_off;
    logic [SLOT_IDX_W-1:0]   slot_ridx;

    // Events on the first edge after reset release are dropped, which covers
    // a strobe that coincides with the deassertion edge.
    assign rx_ev     = rx_done && armed_q;
    assign rd_ev     = rd && armed_q;
    assign slot_off  = OFF_W'(address) - OFF_W'(BASE_ADDR);
    assign slot_hit  = rd_ev && (slot_off < OFF_W'(NUM_SLOTS));
    assign stat_hit  = rd_ev && (address == STAT_ADDR);
    assign slot_ridx = slot_off[SLOT_IDX_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FILLING;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a status read always wins over an incoming byte in FULL
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILLING: begin
                if (rx_ev && (count_q == CNT_W'(NUM_SLOTS - 1))) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (stat_hit) begin
                    state_d = ST_FILLING;
                end
            end
            default: state_d = ST_FILLING;
        endcase
    end

    // Outputs and datapath next values; release happens before the store
    always_comb begin
        count_d   = count_q;
        full_d    = full_q;
        overrun_d = overrun_q;
        slot_we   = 1'b0;
        slot_widx = count_q[SLOT_IDX_W-1:0];
        case (state_q)
            ST_FILLING: begin
                if (stat_hit) begin
                    overrun_d = 1'b0;
                end
                if (rx_ev) begin
                    slot_we = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    full_d  = (count_q == CNT_W'(NUM_SLOTS - 1));
                end
            end
            ST_FULL: begin
                if (stat_hit) begin
                    overrun_d = 1'b0;
                    full_d    = 1'b0;
                    count_d   = '0;
                    if (rx_ev) begin
                        slot_we   = 1'b1;
                        slot_widx = '0;
                        count_d   = CNT_W'(1);
                    end
                end else if (rx_ev) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                count_d   = '0;
                full_d    = 1'b0;
                overrun_d = 1'b0;
            end
        endcase
    end

    // CPU read mux samples pre-edge state, so reads never see same-edge writes
    always_comb begin
        r_data_d = r_data_q;
        if (rd_ev) begin
            if (slot_hit) begin
                r_data_d = slot_q[slot_ridx];
            end else if (stat_hit) begin
                r_data_d = rx_status(count_q, overrun_q, full_q);
            end else begin
                r_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
            r_data_q  <= '0;
            armed_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
            r_data_q  <= r_data_d;
            armed_q   <= 1'b1;
        end
    end

    // Slots survive a release; the next frame overwrites them in place
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else if (slot_we) begin
            slot_q[slot_widx] <= rx_data;
        end
    end

    assign r_data  = r_data_q;
    assign full    = full_q;
    assign overrun = overrun_q;
    assign count   = count_q;

endmodule
